// File: rtl/powlib_bus_pkg.sv
// Shared constants and width helpers for the powlib bus lane blocks.
package powlib_bus_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Window compares carry one extra bit so that a window may end exactly at 2**aw.
    function automatic int b_high(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/powlib_busfifo.sv
// Single-clock output FIFO for a bus lane, with a nearly-full flag taken from the registered fill.
module powlib_busfifo
    import powlib_bus_pkg::*;
#(
    parameter string ID     = "BUSFIFO",
    parameter int    S      = 0,
    parameter int    EASYNC = 0,
    parameter int    D      = 8,
    parameter int    NFS    = 2,
    parameter int    W      = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] wrdata,
    input  logic         wrvld,
    output logic [W-1:0] rddata,
    output logic         rdvld,
    input  logic         rdrdy,
    output logic         nf
);

    localparam int AW = $clog2(D);
    localparam int CW = $clog2(D + 1);

    if (S != 0 || EASYNC != 0 || D < 4 || NFS < 2 || NFS >= D) begin : g_bad_cfg
        $error("%s: unsupported FIFO configuration", ID);
    end

    logic [W-1:0]  mem [D];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          push;
    logic          pop;

    assign full   = (count == CW'(D));
    assign push   = wrvld && !full;
    assign pop    = rdvld && rdrdy;
    assign rdvld  = (count != '0);
    assign rddata = mem[rd_ptr];
    assign nf     = (count >= CW'(D - NFS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == AW'(D - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == AW'(D - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left unreset; only the pointers and fill carry state.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wrdata;
        end
    end

endmodule

// File: rtl/powlib_busarb_lane.sv
// One crossbar output lane: window decode, fixed or round-robin arbitration,
// a two-stage register pipeline and an output FIFO providing backpressure.
module powlib_busarb_lane
    import powlib_bus_pkg::*;
#(
    parameter int              EAR    = 1,
    parameter string           ID     = "ARBLANE",
    parameter int              EDBG   = 0,
    parameter int              B_WRS  = 4,
    parameter int              B_AW   = 8,
    parameter int              B_DW   = 16,
    parameter logic [B_AW-1:0] B_BASE = '0,
    parameter int unsigned     B_SIZE = 2,
    parameter int              ARB    = ARB_RR,
    parameter int              D      = 8,
    parameter int              NFS    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [B_WRS*B_DW-1:0]   wrdatas,
    input  logic [B_WRS*B_AW-1:0]   wraddrs,
    input  logic [B_WRS-1:0]        wrvlds,
    output logic [B_WRS-1:0]        wrrdys,
    output logic [B_DW-1:0]         rddata,
    output logic [B_AW-1:0]         rdaddr,
    output logic                    rdvld,
    input  logic                    rdrdy
);

    localparam int BH  = b_high(B_AW);
    localparam int PW  = (B_WRS > 1) ? $clog2(B_WRS) : 1;
    localparam int PW1 = PW + 1;

    localparam logic [BH-1:0] WIN_BASE = BH'(B_BASE);
    localparam logic [BH-1:0] WIN_END  = BH'(B_BASE) + BH'(B_SIZE);

    if (EAR != 1 || EDBG < 0 || EDBG > 1 || B_WRS < 1 || D < 4 || NFS < 2
        || (ARB != ARB_FIXED && ARB != ARB_RR)) begin : g_bad_cfg
        $error("%s: unsupported lane configuration", ID);
    end

    logic [B_WRS-1:0] hit;
    logic [B_WRS-1:0] rot;
    logic [B_WRS-1:0] grant;
    logic [BH-1:0]    addr_ext;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    gidx;
    logic [PW1-1:0]   gsum;
    logic             found;
    logic             nf;

    logic [B_AW-1:0]  sel_addr;
    logic [B_DW-1:0]  sel_data;
    logic             s1_vld;
    logic [B_AW-1:0]  s1_addr;
    logic [B_DW-1:0]  s1_data;
    logic             s2_vld;
    logic [B_AW-1:0]  s2_addr;
    logic [B_DW-1:0]  s2_data;

    always_comb begin
        hit      = '0;
        addr_ext = '0;
        for (int i = 0; i < B_WRS; i++) begin
            addr_ext = {1'b0, wraddrs[i*B_AW +: B_AW]};
            hit[i]   = wrvlds[i] && (addr_ext >= WIN_BASE) && (addr_ext < WIN_END);
        end
    end

    // Rotate the doubled hit vector so the search always starts at ptr; in fixed
    // priority mode ptr never leaves 0, which makes this a plain lowest-index search.
    always_comb begin
        grant = '0;
        gidx  = '0;
        gsum  = '0;
        found = 1'b0;
        rot   = B_WRS'({hit, hit} >> ptr);
        for (int k = 0; k < B_WRS; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                gsum  = {1'b0, ptr} + PW1'(k);
            end
        end
        gidx = (gsum >= PW1'(B_WRS)) ? PW'(gsum - PW1'(B_WRS)) : PW'(gsum);
        if (found && !nf && rst) begin
            grant[gidx] = 1'b1;
        end
    end

    assign wrrdys = grant;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < B_WRS; i++) begin
            if (grant[i]) begin
                sel_addr = wraddrs[i*B_AW +: B_AW];
                sel_data = wrdatas[i*B_DW +: B_DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr    <= '0;
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else begin
            if (ARB == ARB_RR && (|grant)) begin
                ptr <= (gidx == PW'(B_WRS - 1)) ? '0 : gidx + 1'b1;
            end
            s1_vld <= |grant;
            s2_vld <= s1_vld;
        end
    end

    always_ff @(posedge clk) begin
        s1_addr <= sel_addr;
        s1_data <= sel_data;
        s2_addr <= s1_addr;
        s2_data <= s1_data;
    end

    // The nearly-full margin absorbs the two words that may already be in s1/s2.
    powlib_busfifo #(
        .ID     ({ID, "_BUSFIFO"}),
        .S      (0),
        .EASYNC (0),
        .D      (D),
        .NFS    (NFS),
        .W      (B_AW + B_DW)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wrdata ({s2_addr, s2_data}),
        .wrvld  (s2_vld),
        .rddata ({rdaddr, rddata}),
        .rdvld  (rdvld),
        .rdrdy  (rdrdy),
        .nf     (nf)
    );

endmodule

// File: tb/tb_powlib_busarb_lane.sv
// Randomised bench for powlib_busarb_lane against a queue-based lane model.
module tb_powlib_busarb_lane;

    localparam int NW    = 4;
    localparam int DEPTH = 8;
    localparam int NFSV  = 2;
    localparam int WBASE = 'h40;
    localparam int WSIZE = 'h20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] wrdatas = '0;
    logic [31:0] wraddrs = '0;
    logic [3:0]  wrvlds = '0;
    logic        rdrdy = 1'b1;

    logic [3:0]  wrrdys,  wrrdys_fp,  wrrdys_hi;
    logic [15:0] rddata,  rddata_fp,  rddata_hi;
    logic [7:0]  rdaddr,  rdaddr_fp,  rdaddr_hi;
    logic        rdvld,   rdvld_fp,   rdvld_hi;

    always #5 clk = ~clk;

    powlib_busarb_lane #(.EAR(1), .ID("ARBLANE"), .EDBG(0), .B_WRS(4), .B_AW(8), .B_DW(16),
        .B_BASE(8'h40), .B_SIZE(32'h20), .ARB(1), .D(8), .NFS(2)) dut (
        .clk(clk), .rst(rst), .wrdatas(wrdatas), .wraddrs(wraddrs), .wrvlds(wrvlds),
        .wrrdys(wrrdys), .rddata(rddata), .rdaddr(rdaddr), .rdvld(rdvld), .rdrdy(rdrdy));

    powlib_busarb_lane #(.EAR(1), .ID("ARBLANE_FP"), .EDBG(0), .B_WRS(4), .B_AW(8), .B_DW(16),
        .B_BASE(8'h40), .B_SIZE(32'h20), .ARB(0), .D(8), .NFS(2)) dut_fp (
        .clk(clk), .rst(rst), .wrdatas(wrdatas), .wraddrs(wraddrs), .wrvlds(wrvlds),
        .wrrdys(wrrdys_fp), .rddata(rddata_fp), .rdaddr(rdaddr_fp), .rdvld(rdvld_fp), .rdrdy(rdrdy));

    powlib_busarb_lane #(.EAR(1), .ID("ARBLANE_HI"), .EDBG(0), .B_WRS(4), .B_AW(8), .B_DW(16),
        .B_BASE(8'hF0), .B_SIZE(32'h10), .ARB(1), .D(8), .NFS(2)) dut_hi (
        .clk(clk), .rst(rst), .wrdatas(wrdatas), .wraddrs(wraddrs), .wrvlds(wrvlds),
        .wrrdys(wrrdys_hi), .rddata(rddata_hi), .rdaddr(rdaddr_hi), .rdvld(rdvld_hi), .rdrdy(rdrdy));

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        int          enter;
    } entry_t;

    entry_t      mq[$];
    int          cyc;
    int          mptr;
    bit          pend_pop;
    logic [3:0]  exp_rdys;
    logic        exp_rdvld;
    logic [7:0]  exp_addr;
    logic [15:0] exp_data;
    int          checks;
    int          failures;

    function automatic bit in_win(input logic [7:0] a);
        return (int'(a) >= WBASE) && (int'(a) < WBASE + WSIZE);
    endfunction

    function automatic logic [31:0] rand_win_addrs();
        logic [31:0] r;
        for (int i = 0; i < NW; i++) r[i*8 +: 8] = 8'(WBASE + $urandom_range(0, WSIZE - 1));
        return r;
    endfunction

    function automatic logic [63:0] rand_data();
        return {$urandom(), $urandom()};
    endfunction

    task automatic model_reset();
        mq.delete();
        mptr     = 0;
        pend_pop = 1'b0;
    endtask

    // One cycle: edge, drive new inputs, then derive the lane's expected behaviour.
    // A word granted now transfers at the next edge and is readable three edges on.
    task automatic apply_stimulus(input logic [3:0] v, input logic [31:0] a,
                                  input logic [63:0] d, input logic rdy);
        int fill;
        int g;
        int gsel;
        bit found;
        @(posedge clk);
        cyc++;
        if (pend_pop) void'(mq.pop_front());
        #1;
        wrvlds = v;
        wraddrs = a;
        wrdatas = d;
        rdrdy = rdy;
        #1;
        fill = 0;
        foreach (mq[i]) if (mq[i].enter <= cyc) fill++;
        exp_rdvld = (fill > 0);
        exp_addr  = exp_rdvld ? mq[0].addr : 8'h00;
        exp_data  = exp_rdvld ? mq[0].data : 16'h0000;
        exp_rdys  = 4'b0000;
        found = 1'b0;
        gsel  = 0;
        if (fill < DEPTH - NFSV) begin
            for (int k = 0; k < NW; k++) begin
                g = (mptr + k) % NW;
                if (!found && v[g] && in_win(a[g*8 +: 8])) begin
                    found = 1'b1;
                    gsel  = g;
                end
            end
        end
        if (found) begin
            exp_rdys[gsel] = 1'b1;
            mq.push_back('{addr: a[gsel*8 +: 8], data: d[gsel*16 +: 16], enter: cyc + 3});
            mptr = (gsel + 1) % NW;
        end
        pend_pop = exp_rdvld && rdy;
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && mq.size() != 0; n++) apply_stimulus(4'b0000, '0, '0, 1'b1);
        apply_stimulus(4'b0000, '0, '0, 1'b1);
        checks++;
        if (rdvld !== 1'b0) begin
            failures++;
            $display("[TB] FAIL drain_empty rdvld=%b want=0", rdvld);
        end
    endtask

    task automatic test_reset();
        wrvlds  = 4'b1111;
        wraddrs = 32'h41424344;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (wrrdys !== 4'b0000 || wrrdys_fp !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_wrrdys got=%b/%b want=0000", wrrdys, wrrdys_fp);
        end
        checks++;
        if (rdvld !== 1'b0 || rdvld_hi !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_rdvld got=%b/%b want=0", rdvld, rdvld_hi);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        wrvlds = 4'b0000;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_single_writer();
        apply_stimulus(4'b0010, {8'h00, 8'h00, 8'h45, 8'h00}, {16'h0, 16'h0, 16'hBEEF, 16'h0}, 1'b1);
        checks++;
        if (wrrdys !== 4'b0010 || exp_rdys !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL single_grant got=%b want=0010", wrrdys);
        end
        for (int n = 1; n <= 3; n++) begin
            apply_stimulus(4'b0000, '0, '0, 1'b1);
            checks++;
            if (rdvld !== (n == 3) || rdvld !== exp_rdvld) begin
                failures++;
                $display("[TB] FAIL single_latency edge=%0d rdvld=%b want=%b", n, rdvld, (n == 3));
            end
        end
        checks++;
        if (rdaddr !== 8'h45 || rddata !== 16'hBEEF) begin
            failures++;
            $display("[TB] FAIL single_word got=%h/%h want=45/beef", rdaddr, rddata);
        end
    endtask

    task automatic test_outside_window();
        drain();
        for (int n = 0; n < 50; n++) begin
            apply_stimulus(4'b0100, {8'h00, 8'h60, 8'h00, 8'h00}, rand_data(), 1'b1);
            checks++;
            if (wrrdys !== 4'b0000 || rdvld !== 1'b0) begin
                failures++;
                $display("[TB] FAIL outside_window cyc=%0d wrrdys=%b rdvld=%b want 0000/0", n, wrrdys, rdvld);
            end
        end
    endtask

    task automatic test_round_robin();
        drain();
        for (int n = 0; n < 24; n++) begin
            apply_stimulus(4'b1111, rand_win_addrs(), rand_data(), 1'b1);
            checks++;
            if (wrrdys !== exp_rdys) begin
                failures++;
                $display("[TB] FAIL rr_grant cyc=%0d got=%b want=%b", n, wrrdys, exp_rdys);
            end
            checks++;
            if (wrrdys_fp !== 4'b0001) begin
                failures++;
                $display("[TB] FAIL fixed_grant cyc=%0d got=%b want=0001", n, wrrdys_fp);
            end
            checks++;
            if (rdvld !== exp_rdvld || (exp_rdvld && (rdaddr !== exp_addr || rddata !== exp_data))) begin
                failures++;
                $display("[TB] FAIL rr_output cyc=%0d got=%b %h/%h want=%b %h/%h",
                         n, rdvld, rdaddr, rddata, exp_rdvld, exp_addr, exp_data);
            end
        end
    endtask

    task automatic test_backpressure();
        int sent;
        int received;
        drain();
        sent = 0;
        received = 0;
        for (int n = 0; n < 30; n++) begin
            apply_stimulus((sent < 20) ? 4'b0001 : 4'b0000, {24'h0, 8'(8'h40 + sent)},
                           {48'h0, 16'(16'hA000 + sent)}, 1'b0);
            checks++;
            if (wrrdys !== exp_rdys) begin
                failures++;
                $display("[TB] FAIL bp_grant cyc=%0d got=%b want=%b", n, wrrdys, exp_rdys);
            end
            if (exp_rdys[0]) sent++;
        end
        checks++;
        if (sent !== DEPTH || rdvld !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_fill accepted=%0d rdvld=%b want=%0d/1", sent, rdvld, DEPTH);
        end
        for (int n = 0; n < 200 && received < 20; n++) begin
            apply_stimulus((sent < 20) ? 4'b0001 : 4'b0000, {24'h0, 8'(8'h40 + sent)},
                           {48'h0, 16'(16'hA000 + sent)}, 1'b1);
            checks++;
            if (wrrdys !== exp_rdys || rdvld !== exp_rdvld) begin
                failures++;
                $display("[TB] FAIL bp_drain cyc=%0d wrrdys=%b rdvld=%b want=%b/%b",
                         n, wrrdys, rdvld, exp_rdys, exp_rdvld);
            end
            if (exp_rdys[0]) sent++;
            if (pend_pop) begin
                checks++;
                if (rdaddr !== 8'(8'h40 + received) || rddata !== 16'(16'hA000 + received)) begin
                    failures++;
                    $display("[TB] FAIL bp_order idx=%0d got=%h/%h want=%h/%h", received, rdaddr,
                             rddata, 8'(8'h40 + received), 16'(16'hA000 + received));
                end
                received++;
            end
        end
        checks++;
        if (received !== 20) begin
            failures++;
            $display("[TB] FAIL bp_count received=%0d want=20", received);
        end
    endtask

    task automatic test_high_window();
        drain();
        apply_stimulus(4'b1000, {8'hFF, 24'h0}, {16'h1234, 48'h0}, 1'b1);
        checks++;
        if (wrrdys_hi !== 4'b1000 || wrrdys !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL high_accept got=%b/%b want=1000/0000", wrrdys_hi, wrrdys);
        end
        for (int n = 1; n <= 3; n++) begin
            apply_stimulus(4'b0000, '0, '0, 1'b1);
            checks++;
            if (rdvld_hi !== (n == 3)) begin
                failures++;
                $display("[TB] FAIL high_latency edge=%0d rdvld=%b want=%b", n, rdvld_hi, (n == 3));
            end
        end
        checks++;
        if (rdaddr_hi !== 8'hFF || rddata_hi !== 16'h1234) begin
            failures++;
            $display("[TB] FAIL high_word got=%h/%h want=ff/1234", rdaddr_hi, rddata_hi);
        end
        for (int n = 0; n < 10; n++) begin
            apply_stimulus(4'b1000, {8'hEF, 24'h0}, rand_data(), 1'b1);
            checks++;
            if (wrrdys_hi !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL high_reject cyc=%0d got=%b want=0000", n, wrrdys_hi);
            end
        end
    endtask

    task automatic test_reset_midstream();
        bit reached;
        drain();
        reached = 1'b0;
        for (int n = 0; n < 16 && !reached; n++) begin
            apply_stimulus(4'b1111, rand_win_addrs(), rand_data(), 1'b0);
            checks++;
            if (wrrdys !== exp_rdys) begin
                failures++;
                $display("[TB] FAIL mid_grant cyc=%0d got=%b want=%b", n, wrrdys, exp_rdys);
            end
            if (mptr == 2 && mq.size() >= 3) reached = 1'b1;
        end
        checks++;
        if (!reached) begin
            failures++;
            $display("[TB] FAIL mid_setup ptr=%0d inflight=%0d want 2/>=3", mptr, mq.size());
        end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (wrrdys !== 4'b0000 || rdvld !== 1'b0 || wrrdys_fp !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL mid_async wrrdys=%b rdvld=%b fp=%b want 0000/0/0000", wrrdys, rdvld, wrrdys_fp);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (wrrdys !== 4'b0000 || rdvld !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_hold wrrdys=%b rdvld=%b want 0000/0", wrrdys, rdvld);
        end
        @(negedge clk);
        wrvlds = 4'b0000;
        rst = 1'b1;
        apply_stimulus(4'b1111, rand_win_addrs(), rand_data(), 1'b1);
        checks++;
        if (wrrdys !== 4'b0001 || exp_rdys !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL mid_first_grant got=%b want=0001", wrrdys);
        end
        for (int n = 0; n < 8; n++) begin
            apply_stimulus(4'b1111, rand_win_addrs(), rand_data(), 1'b1);
            checks++;
            if (rdvld !== exp_rdvld || (exp_rdvld && rddata !== exp_data)) begin
                failures++;
                $display("[TB] FAIL mid_output cyc=%0d got=%b %h want=%b %h", n, rdvld, rddata, exp_rdvld, exp_data);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NW; i++) a[i*8 +: 8] = 8'(8'h38 + $urandom_range(0, 47));
            apply_stimulus(4'($urandom_range(0, 15)), a, rand_data(), ($urandom_range(0, 3) != 0));
            checks++;
            if (wrrdys !== exp_rdys) begin
                failures++;
                $display("[TB] FAIL rand_grant cyc=%0d got=%b want=%b", n, wrrdys, exp_rdys);
            end
            checks++;
            if (rdvld !== exp_rdvld || (exp_rdvld && (rdaddr !== exp_addr || rddata !== exp_data))) begin
                failures++;
                $display("[TB] FAIL rand_output cyc=%0d got=%b %h/%h want=%b %h/%h",
                         n, rdvld, rdaddr, rddata, exp_rdvld, exp_addr, exp_data);
            end
        end
        drain();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        model_reset();
        test_reset();
        test_single_writer();
        test_outside_window();
        test_round_robin();
        test_backpressure();
        test_high_window();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog time=%0t limit=200000", $time);
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
